// File: rtl/mips16_pkg.sv
// Shared encodings for the mips16 multicycle controller: opcodes, ALU op codes,
// FSM states and datapath mux selects.
package mips16_pkg;

    localparam int OPCODE_WIDTH   = 4;
    localparam int FUNCT_WIDTH    = 3;
    localparam int ALU_CTRL_WIDTH = 3;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_RTYPE = 4'b0000,
        OP_LW    = 4'b0001,
        OP_SW    = 4'b0010,
        OP_BEQ   = 4'b0011,
        OP_ADDI  = 4'b0100,
        OP_J     = 4'b0101
    } opcode_t;

    typedef enum logic [ALU_CTRL_WIDTH-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b100
    } alu_ctrl_t;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } ctrl_state_t;

    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_TWO    = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    function automatic logic funct_is_legal(input logic [FUNCT_WIDTH-1:0] funct);
        return (funct <= 3'b100);
    endfunction

    function automatic alu_ctrl_t funct_to_alu(input logic [FUNCT_WIDTH-1:0] funct);
        case (funct)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SUB;
            3'b010:  return ALU_AND;
            3'b011:  return ALU_OR;
            3'b100:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// R-type funct to ALU op code mapping; non-R phases always request ADD.
module alu_decoder
    import mips16_pkg::*;
(
    input  logic [FUNCT_WIDTH-1:0]    funct,
    input  logic                      is_rtype,
    output logic [ALU_CTRL_WIDTH-1:0] alu_control,
    output logic                      illegal_funct
);

    always_comb begin
        alu_control   = ALU_ADD;
        illegal_funct = 1'b0;
        if (is_rtype) begin
            if (funct_is_legal(funct)) begin
                alu_control = funct_to_alu(funct);
            end else begin
                illegal_funct = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mips16_multicycle_control.sv
// Multicycle control FSM for the 16-bit MIPS core. Datapath controls are decoded
// from the state register; strobes are additionally masked while reset is high.
module mips16_multicycle_control
    import mips16_pkg::*;
#(
    parameter int OPCODE_W   = OPCODE_WIDTH,
    parameter int FUNCT_W    = FUNCT_WIDTH,
    parameter int ALU_CTRL_W = ALU_CTRL_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic [FUNCT_W-1:0]    funct,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            pc_src,
    output logic                  pc_en,
    output logic                  ir_write,
    output logic                  i_or_d,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic                  reg_dst,
    output logic                  mem_to_reg,
    output logic                  reg_write,
    output logic                  illegal_op
);

    localparam int N_STROBE = 6;

    ctrl_state_t state_q, state_d;

    logic [ALU_CTRL_W-1:0] dec_alu;
    logic                  dec_illegal;
    logic                  rtype_phase;

    logic [ALU_CTRL_W-1:0] alu_ctrl_c;
    logic                  src_a_c;
    logic [1:0]            src_b_c;
    logic [1:0]            pc_src_c;
    logic                  pc_write_c;
    logic                  branch_c;
    logic                  ir_write_c;
    logic                  i_or_d_c;
    logic                  mem_req_c;
    logic                  mem_write_c;
    logic                  reg_dst_c;
    logic                  mem_to_reg_c;
    logic                  reg_write_c;
    logic                  illegal_c;

    logic [N_STROBE-1:0]   strobe_raw;
    logic [N_STROBE-1:0]   strobe_gated;

    // funct is only meaningful while the R-type instruction sits in EXECUTE/ALUWB
    assign rtype_phase = (state_q == S_EXECUTE) || (state_q == S_ALUWB);

    alu_decoder u_alu_decoder (
        .funct         (funct),
        .is_rtype      (rtype_phase),
        .alu_control   (dec_alu),
        .illegal_funct (dec_illegal)
    );

    always_comb begin
        state_d      = state_q;
        alu_ctrl_c   = ALU_ADD;
        src_a_c      = 1'b0;
        src_b_c      = SRC_B_REG;
        pc_src_c     = PC_SRC_ALU;
        pc_write_c   = 1'b0;
        branch_c     = 1'b0;
        ir_write_c   = 1'b0;
        i_or_d_c     = 1'b0;
        mem_req_c    = 1'b0;
        mem_write_c  = 1'b0;
        reg_dst_c    = 1'b0;
        mem_to_reg_c = 1'b0;
        reg_write_c  = 1'b0;
        illegal_c    = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                src_b_c   = SRC_B_TWO;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculatively form the branch target into ALUOut.
                src_b_c = SRC_B_IMM_SH;
                case (opcode)
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                src_a_c = 1'b1;
                src_b_c = SRC_B_IMM;
                state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req_c = 1'b1;
                i_or_d_c  = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                mem_to_reg_c = 1'b1;
                reg_write_c  = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                mem_req_c   = 1'b1;
                mem_write_c = 1'b1;
                i_or_d_c    = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_EXECUTE: begin
                src_a_c    = 1'b1;
                alu_ctrl_c = dec_alu;
                illegal_c  = dec_illegal;
                state_d    = dec_illegal ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                alu_ctrl_c  = dec_alu;
                reg_dst_c   = 1'b1;
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                src_a_c    = 1'b1;
                alu_ctrl_c = ALU_SUB;
                pc_src_c   = PC_SRC_ALUOUT;
                branch_c   = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDIEX: begin
                src_a_c = 1'b1;
                src_b_c = SRC_B_IMM;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                pc_src_c   = PC_SRC_JUMP;
                pc_write_c = 1'b1;
                state_d    = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign strobe_raw = {pc_write_c | (branch_c & zero), ir_write_c, mem_req_c,
                         mem_write_c, reg_write_c, illegal_c};

    // Strobes are masked in the reset cycle itself so an in-flight access is abandoned at once.
    generate
        for (genvar gi = 0; gi < N_STROBE; gi++) begin : g_strobe_mask
            assign strobe_gated[gi] = strobe_raw[gi] & ~reset;
        end
    endgenerate

    assign {pc_en, ir_write, mem_req, mem_write, reg_write, illegal_op} = strobe_gated;

    assign alu_control = alu_ctrl_c;
    assign alu_src_a   = src_a_c;
    assign alu_src_b   = src_b_c;
    assign pc_src      = pc_src_c;
    assign i_or_d      = i_or_d_c;
    assign reg_dst     = reg_dst_c;
    assign mem_to_reg  = mem_to_reg_c;

endmodule
